i2c_slave_regfile: RTL and testbench

I2C responder (target) paired with the team's I2C master controller. Presents a byte-addressed register file at a fixed 7-bit device address and serves the standard EEPROM-style random write, random read, current-address read and sequential access.
Used as an on-chip peripheral and as a synthesizable loopback target for master bring-up. SCL and SDA are oversampled on the 50 MHz system clock.

---
 rtl/i2c_slave_regfile.sv | 226 ++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a 2^REG_AW byte register file at a fixed 7-bit address.
// Supports EEPROM-style random write, random read, current-address read and sequential access.
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         REG_AW   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i2c_sclk,
    inout  wire               i2c_sdat,
    output logic              i2c_busy,
    output logic              reg_wr_en,
    output logic [REG_AW-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_data
);

    localparam int DEPTH = 1 << REG_AW;

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_ADDR, ST_REG_ACK,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        scl_q, scl_d;
    logic [2:0]        sda_q, sda_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        mem_q [DEPTH];

    logic              scl_rise_s, scl_fall_s, start_s, stop_s, sda_bit_s;
    logic [7:0]        byte_s, rd_byte_s;

    // [0] and [1] form the synchronizer, [2] is the history flop used for edge detection
    assign scl_rise_s = scl_q[1] & ~scl_q[2];
    assign scl_fall_s = ~scl_q[1] & scl_q[2];
    assign start_s    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_s     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign sda_bit_s  = sda_q[1];
    assign byte_s     = {shift_q[6:0], sda_bit_s};
    assign rd_byte_s  = mem_q[ptr_q];

    assign i2c_sdat    = sda_oe_q ? 1'b0 : 1'bz;
    assign i2c_busy    = busy_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;

    // Next-state logic: bus conditions first, then per-state bit handling
    always_comb begin
        scl_d     = {scl_q[1:0], i2c_sclk};
        sda_d     = {sda_q[1:0], i2c_sdat};
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // STOP outranks a simultaneous START
        if (stop_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_s) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_d = byte_s;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (state_q == ST_DEV_ADDR) begin
                                if (byte_s[7:1] == DEV_ADDR) begin
                                    state_d = ST_DEV_ACK;
                                    rw_d    = byte_s[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_WAIT_STOP;
                                end
                            end else if (state_q == ST_REG_ADDR) begin
                                ptr_d   = byte_s[REG_AW-1:0];
                                state_d = ST_REG_ACK;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = byte_s;
                                ptr_d     = ptr_q + REG_AW'(1);
                                state_d   = ST_WR_ACK;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
                    // First falling edge starts the ACK, second one ends it
                    if (scl_fall_s) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            bit_cnt_d = 4'd0;
                            sda_oe_d  = 1'b0;
                            if (state_q == ST_DEV_ACK && rw_q) begin
                                shift_d  = rd_byte_s;
                                sda_oe_d = ~rd_byte_s[7];
                                ptr_d    = ptr_q + REG_AW'(1);
                                state_d  = ST_RD_DATA;
                            end else if (state_q == ST_DEV_ACK) begin
                                state_d = ST_REG_ADDR;
                            end else begin
                                state_d = ST_WR_DATA;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s && bit_cnt_q == 4'd0) begin
                        if (!sda_bit_s) begin
                            bit_cnt_d = 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WAIT_STOP;
                        end
                    end else if (scl_fall_s && bit_cnt_q == 4'd1) begin
                        shift_d   = rd_byte_s;
                        sda_oe_d  = ~rd_byte_s[7];
                        ptr_d     = ptr_q + REG_AW'(1);
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RD_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    state_d = state_q;
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Control and output registers; reset releases SDA immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            scl_q     <= 3'b111;
            sda_q     <= 3'b111;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file storage, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (wr_en_d) begin
            mem_q[wr_addr_d] <= wr_data_d;
        end else begin
            mem_q[wr_addr_d] <= mem_q[wr_addr_d];
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bit-banged I2C master runs a table of bus operations,
// followed by hand-written abort and reset-during-ACK sequences.
module tb_i2c_slave_regfile;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WR    = 2'd2;
    localparam logic [1:0] OP_RD    = 2'd3;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;     // byte written by the master (OP_WR)
        logic       ack_in;   // master ACK(0)/NACK(1) after a read byte
        logic [7:0] exp_data; // expected read byte (OP_RD)
        logic       exp_ack;  // expected bit on the 9th clock of a write (1 = not driven)
        logic       exp_busy; // expected i2c_busy after the operation
        logic       clr;      // take a new quiet-bus baseline after the operation
        logic       chk;      // check the bus stayed quiet since the baseline, before the operation
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_drv = 1'b0;
    wire        sda_bus;
    logic       i2c_busy, reg_wr_en;
    logic [7:0] reg_wr_addr, reg_wr_data;

    int         tests = 0;
    int         fails = 0;
    int         dut_low_cnt = 0;
    int         quiet_base = 0;
    logic [15:0] wr_log[$];
    vec_t       vecs[$];

    assign sda_bus = m_drv ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_slave_regfile #(.DEV_ADDR(7'h50), .REG_AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .i2c_sclk(scl), .i2c_sdat(sda_bus),
        .i2c_busy(i2c_busy), .reg_wr_en(reg_wr_en),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && reg_wr_en) wr_log.push_back({reg_wr_addr, reg_wr_data});
        if (!m_drv && sda_bus == 1'b0) dut_low_cnt = dut_low_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_drv = 1'b0; wait_clk(4);
        scl = 1'b1;   wait_clk(10);
        m_drv = 1'b1; wait_clk(10);
        scl = 1'b0;   wait_clk(4);
    endtask

    task automatic i2c_stop();
        m_drv = 1'b1; wait_clk(4);
        scl = 1'b1;   wait_clk(10);
        m_drv = 1'b0; wait_clk(10);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(4);
        m_drv = ~b;  wait_clk(6);
        scl = 1'b1;  wait_clk(10);
        scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        logic early;
        m_drv = 1'b0; wait_clk(10);
        scl = 1'b1;   wait_clk(2);
        early = sda_bus; wait_clk(7);
        b = sda_bus;
        check("sda_stable_high", b, early);
        wait_clk(1);
        scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic ack_in, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) recv_bit(d[i]);
        send_bit(ack_in);
        m_drv = 1'b0;
    endtask

    task automatic add(input logic [1:0] op, input logic [7:0] data, input logic ack_in,
                       input logic [7:0] exp_data, input logic exp_ack, input logic exp_busy,
                       input logic clr, input logic chk);
        vec_t v;
        v.op = op; v.data = data; v.ack_in = ack_in; v.exp_data = exp_data;
        v.exp_ack = exp_ack; v.exp_busy = exp_busy; v.clr = clr; v.chk = chk;
        vecs.push_back(v);
    endtask

    initial begin
        logic       bit_v;
        logic [7:0] byte_v;
        int         base;

        // write, ACK, two commits
        add(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add(OP_WR,    8'hA0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_WR,    8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_WR,    8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_WR,    8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // pointer wrap FF -> 00
        add(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add(OP_WR,    8'hA0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_WR,    8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_WR,    8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_WR,    8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // random read from 0x12 with repeated START
        add(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        add(OP_WR,    8'hA0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_WR,    8'h12, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_WR,    8'hA1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_RD,    8'h00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_RD,    8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        add(OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // current-address read continues at 0x14
        add(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        add(OP_WR,    8'hA1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_RD,    8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        // address mismatch: never ACKs, never busy
        add(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        add(OP_WR,    8'hA2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(OP_WR,    8'h12, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(OP_WR,    8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(OP_STOP,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        wait_clk(5);
        check("rst_busy", i2c_busy, 1'b0);
        check("rst_wr_en", reg_wr_en, 1'b0);
        check("rst_wr_addr", reg_wr_addr, 8'h00);
        check("rst_wr_data", reg_wr_data, 8'h00);
        check("rst_sda", sda_bus, 1'b1);
        rst_n = 1'b1;
        wait_clk(10);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].chk) check($sformatf("quiet[%0d]", i), dut_low_cnt - quiet_base, 0);
            case (vecs[i].op)
                OP_START: i2c_start();
                OP_STOP:  i2c_stop();
                OP_WR: begin
                    write_byte(vecs[i].data, bit_v);
                    check($sformatf("ack[%0d]", i), bit_v, vecs[i].exp_ack);
                end
                default: begin
                    read_byte(vecs[i].ack_in, byte_v);
                    check($sformatf("rd[%0d]", i), byte_v, vecs[i].exp_data);
                end
            endcase
            check($sformatf("busy[%0d]", i), i2c_busy, vecs[i].exp_busy);
            if (vecs[i].clr) quiet_base = dut_low_cnt;
        end

        check("wr_count", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            check("wr0", wr_log[0], 16'h125A);
            check("wr1", wr_log[1], 16'h133C);
            check("wr2", wr_log[2], 16'hFF11);
            check("wr3", wr_log[3], 16'h0022);
        end

        // abort a data byte after 4 bits with a repeated START
        base = wr_log.size();
        i2c_start();
        write_byte(8'hA0, bit_v);
        write_byte(8'h30, bit_v);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        i2c_start();
        check("abort_no_write", wr_log.size() - base, 0);
        write_byte(8'hA0, bit_v);
        check("abort_dev_ack", bit_v, 1'b0);
        write_byte(8'h40, bit_v);
        write_byte(8'h77, bit_v);
        check("abort_data_ack", bit_v, 1'b0);
        i2c_stop();
        check("abort_wr_count", wr_log.size() - base, 1);
        if (wr_log.size() == base + 1) check("abort_wr", wr_log[base], 16'h4077);

        // reset while the DUT pulls SDA low for the address ACK of a read
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(logic'((8'hA1 >> i) & 8'h01));
        m_drv = 1'b0;
        wait_clk(6);
        check("ack_before_reset", sda_bus, 1'b0);
        rst_n = 1'b0;
        #1;
        check("sda_released_in_reset", sda_bus, 1'b1);
        check("busy_in_reset", i2c_busy, 1'b0);
        wait_clk(2);
        scl = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(10);
        i2c_start();
        write_byte(8'hA0, bit_v);
        write_byte(8'h12, bit_v);
        i2c_start();
        write_byte(8'hA1, bit_v);
        check("post_reset_ack", bit_v, 1'b0);
        read_byte(1'b1, byte_v);
        check("post_reset_reg12", byte_v, 8'h00);
        i2c_stop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
